// File: rtl/instruction_fetch.sv
// Fetch control stage: program memory, loader write port and the IDLE/FETCH/EXEC/HALT
// sequencer that gates PC advance and stops on the HALT opcode.
module instruction_fetch #(
  parameter int               MSB      = 11,
  parameter int               DATA_W   = 16,
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'b00000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [MSB-1:0]    i_pc,
  input  logic              i_load_we,
  input  logic [MSB-1:0]    i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  output logic              o_pc_en,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_valid,
  output logic              o_halt,
  output logic [1:0]        o_state,
  output logic [15:0]       o_icount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam int DEPTH = 2 ** MSB;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q, state_d;
  logic              rd_en, wr_en, cnt_clr, cnt_inc;
  logic [15:0]       icount_q;
  logic [OPC_W-1:0]  opcode;

  assign opcode = o_instr[DATA_W-1 -: OPC_W];

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_en = i_load_we;
        // A loader write wins over start in the same cycle.
        if (i_start && !i_load_we) begin
          state_d = S_FETCH;
          cnt_clr = 1'b1;
        end
      end
      S_FETCH: begin
        if (!i_step_mode || i_step) begin
          rd_en   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_inc = 1'b1;
        state_d = (opcode != HALT_OPC) ? S_FETCH : S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the memory array has no reset; contents survive reset and are undefined until loaded.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[i_load_addr] <= i_load_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     o_instr <= '0;
    else if (rd_en) o_instr <= mem[i_pc];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                          icount_q <= '0;
    else if (cnt_clr)                    icount_q <= '0;
    else if (cnt_inc && icount_q != '1)  icount_q <= icount_q + 16'd1;
  end

  // Outputs decode only registered state and o_instr.
  assign o_valid  = (state_q == S_EXEC);
  assign o_pc_en  = (state_q == S_EXEC) && (opcode != HALT_OPC);
  assign o_halt   = (state_q == S_HALT);
  assign o_state  = state_q;
  assign o_icount = icount_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: free-run, single-step, blocked load,
// start/load collision, asynchronous reset mid-EXEC and counter saturation.
module tb_instruction_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [10:0] i_pc;
  logic        i_load_we   = 1'b0;
  logic [10:0] i_load_addr = '0;
  logic [15:0] i_load_data = '0;
  logic        i_start     = 1'b0;
  logic        i_step_mode = 1'b0;
  logic        i_step      = 1'b0;
  logic        o_pc_en;
  logic [15:0] o_instr;
  logic        o_valid;
  logic        o_halt;
  logic [1:0]  o_state;
  logic [15:0] o_icount;

  logic        pc_hold = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  instruction_fetch dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pc        (i_pc),
    .i_load_we   (i_load_we),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .i_start     (i_start),
    .i_step_mode (i_step_mode),
    .i_step      (i_step),
    .o_pc_en     (o_pc_en),
    .o_instr     (o_instr),
    .o_valid     (o_valid),
    .o_halt      (o_halt),
    .o_state     (o_state),
    .o_icount    (o_icount)
  );

  always #5 i_clk = ~i_clk;

  // Program counter stub: increments on o_pc_en, or holds at 0 to emulate a jump-to-0 loop.
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                   i_pc <= '0;
    else if (o_pc_en && !pc_hold) i_pc <= i_pc + 11'd1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic [15:0] instr,
                            input logic valid, input logic pc_en, input logic halt);
    check({tag, ".state"}, 32'(o_state), 32'(st));
    check({tag, ".instr"}, 32'(o_instr), 32'(instr));
    check({tag, ".valid"}, 32'(o_valid), 32'(valid));
    check({tag, ".pc_en"}, 32'(o_pc_en), 32'(pc_en));
    check({tag, ".halt"},  32'(o_halt),  32'(halt));
  endtask

  task automatic load(input logic [10:0] addr, input logic [15:0] data);
    i_load_we   = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    tick();
    i_load_we   = 1'b0;
  endtask

  task automatic do_reset();
    #2 i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 i_rst = 1'b0;
    #2;
    check_outs("reset", 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("reset.icount", 32'(o_icount), 32'h0);
    tick();
    i_rst = 1'b1;

    // Load and free-run
    load(11'd0, 16'h0801);
    load(11'd1, 16'h1002);
    load(11'd2, 16'h0000);
    check("load.idle", 32'(o_state), 32'h0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_outs("run.f0", 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("run.e0", 2'b10, 16'h0801, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("run.f1", 2'b01, 16'h0801, 1'b0, 1'b0, 1'b0);
    check("run.pc1", 32'(i_pc), 32'd1);
    tick();
    check_outs("run.e1", 2'b10, 16'h1002, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check_outs("run.e2", 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("run.e2.icount", 32'(o_icount), 32'd2);
    tick();
    check_outs("run.halt", 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("run.icount", 32'(o_icount), 32'd3);
    i_start = 1'b1;
    i_step  = 1'b1;
    tick();
    tick();
    i_start = 1'b0;
    i_step  = 1'b0;
    check_outs("run.halt_sticky", 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("run.pc_final", 32'(i_pc), 32'd2);

    // Single-step with a blocked load during FETCH of address 0
    do_reset();
    i_step_mode = 1'b1;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        i_load_we   = 1'b1;
        i_load_addr = 11'd1;
        i_load_data = 16'hFFFF;
      end
      if (i == 5) i_load_we = 1'b0;
      tick();
      check("step.wait.state", 32'(o_state), 32'h1);
      check("step.wait.valid", 32'(o_valid), 32'h0);
    end
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    check_outs("step.e0", 2'b10, 16'h0801, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("step.f1", 2'b01, 16'h0801, 1'b0, 1'b0, 1'b0);
    tick();
    check("step.f1.hold", 32'(o_state), 32'h1);
    i_step = 1'b1;
    tick();
    check_outs("step.e1", 2'b10, 16'h1002, 1'b1, 1'b1, 1'b0);
    tick();
    i_step = 1'b0;
    tick();
    check_outs("step.drop", 2'b01, 16'h1002, 1'b0, 1'b0, 1'b0);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    check_outs("step.e2", 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("step.halt", 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("step.icount", 32'(o_icount), 32'd3);
    i_step_mode = 1'b0;

    // Start/load collision: mem[0] becomes HALT, start ignored that cycle
    do_reset();
    i_start     = 1'b1;
    i_load_we   = 1'b1;
    i_load_addr = 11'd0;
    i_load_data = 16'h0000;
    tick();
    i_load_we = 1'b0;
    check("coll.idle", 32'(o_state), 32'h0);
    tick();
    i_start = 1'b0;
    check("coll.fetch", 32'(o_state), 32'h1);
    tick();
    check_outs("coll.e0", 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    check("coll.halt", 32'(o_halt), 32'h1);
    check("coll.icount", 32'(o_icount), 32'd1);

    // Asynchronous reset mid-EXEC, then restart from mem[0]
    do_reset();
    load(11'd0, 16'h0801);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check_outs("arst.pre", 2'b10, 16'h0801, 1'b1, 1'b1, 1'b0);
    #2 i_rst = 1'b0;
    #1;
    check_outs("arst.now", 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("arst.icount", 32'(o_icount), 32'h0);
    tick();
    i_rst = 1'b1;
    tick();
    check("arst.idle", 32'(o_state), 32'h0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check_outs("arst.re0", 2'b10, 16'h0801, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_outs("arst.re2", 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    check("arst.halt", 32'(o_halt), 32'h1);
    check("arst.icount3", 32'(o_icount), 32'd3);

    // Counter saturation on a non-HALT jump-to-0 loop
    do_reset();
    load(11'd0, 16'h0800);
    pc_hold = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tick();
    end
    check_outs("sat.loop", 2'b01, 16'h0800, 1'b0, 1'b0, 1'b0);
    check("sat.count5", 32'(o_icount), 32'd5);
    force dut.icount_q = 16'hFFFD;
    tick();
    tick();
    release dut.icount_q;
    for (int i = 0; i < 8; i++) tick();
    check("sat.ffff", 32'(o_icount), 32'hFFFF);
    for (int i = 0; i < 8; i++) tick();
    check("sat.hold", 32'(o_icount), 32'hFFFF);
    check("sat.running", 32'(o_halt), 32'h0);
    pc_hold = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
